// File: rtl/issue_arbiter.sv
// issue_arbiter: round-robin selection of one ready instruction-buffer head per
// cycle. The winner lands in a single-entry output register that feeds the
// issue stage through a valid/ready handshake.
// Optional build macro ISSUE_ARBITER_PERF_EN adds the perf_issued and
// perf_backpressure counters.

module issue_arbiter #(
   parameter int NUM_WARPS = 8,
   parameter int ARCH_LEN  = 32,
   parameter int INST_BITS = 64,
   parameter int NUM_LANES = 16,
   localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_WARPS-1:0]            ibuf_valid,
   output logic [NUM_WARPS-1:0]            ibuf_ready,
   input  logic [NUM_WARPS*ARCH_LEN-1:0]   ibuf_pc,
   input  logic [NUM_WARPS*INST_BITS-1:0]  ibuf_raw,
   input  logic [NUM_WARPS*NUM_LANES-1:0]  ibuf_tmask,
   input  logic [NUM_WARPS-1:0]            warp_stall,
   input  logic                            flush_valid,
   input  logic [WID_BITS-1:0]             flush_wid,
   output logic                            iss_valid,
   input  logic                            iss_ready,
   output logic [WID_BITS-1:0]             iss_wid,
   output logic [ARCH_LEN-1:0]             iss_pc,
   output logic [INST_BITS-1:0]            iss_raw,
   output logic [NUM_LANES-1:0]            iss_tmask
`ifdef ISSUE_ARBITER_PERF_EN
   ,
   output logic [31:0]                     perf_issued,
   output logic [31:0]                     perf_backpressure
`endif
);

   logic [WID_BITS-1:0]  last_grant;
   logic [NUM_WARPS-1:0] flush_mask;
   logic [NUM_WARPS-1:0] cand;
   logic                 load_en;
   logic                 found;
   logic [WID_BITS-1:0]  win;
   logic                 grant;

   // Eligible heads: valid, not held by the scoreboard, and not being flushed.
   always_comb begin
      flush_mask = '0;
      for (int g = 0; g < NUM_WARPS; g++) begin
         flush_mask[g] = flush_valid && (flush_wid == WID_BITS'(g));
      end
      cand    = ibuf_valid & ~warp_stall & ~flush_mask;
      load_en = !iss_valid || iss_ready;
   end

   // Round-robin pick: first eligible warp searching upward from last_grant+1, wrapping.
   always_comb begin
      int                  idx;
      logic [WID_BITS-1:0] idx_w;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      idx_w = '0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         idx   = (int'(last_grant) + i) % NUM_WARPS;
         idx_w = WID_BITS'(idx);
         if (!found && cand[idx_w]) begin
            found = 1'b1;
            win   = idx_w;
         end
      end
      grant = !reset && load_en && found;
   end

   // Dequeue strobe goes one-hot to the winner only on a real grant.
   always_comb begin
      ibuf_ready = '0;
      for (int g = 0; g < NUM_WARPS; g++) begin
         ibuf_ready[g] = grant && (win == WID_BITS'(g));
      end
   end

   // Output register: load on grant, drain on handshake, drop a held entry whose warp is flushed.
   always_ff @(posedge clock) begin
      if (reset) begin
         iss_valid  <= 1'b0;
         iss_wid    <= '0;
         iss_pc     <= '0;
         iss_raw    <= '0;
         iss_tmask  <= '0;
         last_grant <= WID_BITS'(NUM_WARPS - 1);
      end else if (grant) begin
         iss_valid  <= 1'b1;
         iss_wid    <= win;
         iss_pc     <= ibuf_pc[int'(win)*ARCH_LEN +: ARCH_LEN];
         iss_raw    <= ibuf_raw[int'(win)*INST_BITS +: INST_BITS];
         iss_tmask  <= ibuf_tmask[int'(win)*NUM_LANES +: NUM_LANES];
         last_grant <= win;
      end else if (load_en) begin
         iss_valid <= 1'b0;
      end else if (flush_valid && (flush_wid == iss_wid)) begin
         iss_valid <= 1'b0;
      end
   end

`ifdef ISSUE_ARBITER_PERF_EN
   // Count completed issues and cycles the issue stage pushed back; both wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_issued       <= '0;
         perf_backpressure <= '0;
      end else begin
         if (iss_valid && iss_ready) begin
            perf_issued <= perf_issued + 32'd1;
         end
         if (iss_valid && !iss_ready) begin
            perf_backpressure <= perf_backpressure + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_issue_arbiter.sv
// tb_issue_arbiter: directed vector table for the documented scenarios, then
// randomized traffic compared against a transaction-level model of the arbiter.

module tb_issue_arbiter;

   localparam int NW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic [NW-1:0] ibuf_valid;
   logic [NW-1:0] ibuf_ready;
   logic [NW*32-1:0] ibuf_pc;
   logic [NW*64-1:0] ibuf_raw;
   logic [NW*16-1:0] ibuf_tmask;
   logic [NW-1:0] warp_stall;
   logic          flush_valid;
   logic [2:0]    flush_wid;
   logic          iss_valid;
   logic          iss_ready;
   logic [2:0]    iss_wid;
   logic [31:0]   iss_pc;
   logic [63:0]   iss_raw;
   logic [15:0]   iss_tmask;
`ifdef ISSUE_ARBITER_PERF_EN
   logic [31:0]   perf_issued;
   logic [31:0]   perf_backpressure;
`endif

   int n_checks = 0;
   int n_errors = 0;

   issue_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .ibuf_valid (ibuf_valid),
      .ibuf_ready (ibuf_ready),
      .ibuf_pc    (ibuf_pc),
      .ibuf_raw   (ibuf_raw),
      .ibuf_tmask (ibuf_tmask),
      .warp_stall (warp_stall),
      .flush_valid(flush_valid),
      .flush_wid  (flush_wid),
      .iss_valid  (iss_valid),
      .iss_ready  (iss_ready),
      .iss_wid    (iss_wid),
      .iss_pc     (iss_pc),
      .iss_raw    (iss_raw),
      .iss_tmask  (iss_tmask)
`ifdef ISSUE_ARBITER_PERF_EN
      ,
      .perf_issued      (perf_issued),
      .perf_backpressure(perf_backpressure)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   typedef struct {
      logic          rst;
      logic [NW-1:0] valid;
      logic [NW-1:0] stall;
      logic          ready;
      logic          fv;
      logic [2:0]    fw;
      logic [NW-1:0] e_rdy;
      logic          e_vld;
      logic [2:0]    e_wid;
   } vec_t;

   vec_t vecs[$];

   // Model state for the randomized phase.
   logic        m_valid;
   logic [2:0]  m_wid;
   logic [31:0] m_pc;
   logic [63:0] m_raw;
   logic [15:0] m_tmask;
   int          m_last;

   function automatic logic [31:0] pc_of(int g);
      return 32'h8000_0000 + 32'(g) * 32'h40;
   endfunction

   function automatic logic [63:0] raw_of(int g);
      return {32'hC0DE_0000 + 32'(g), 32'h1234_0000 + 32'(g)};
   endfunction

   function automatic logic [15:0] tmask_of(int g);
      return 16'hFFFF >> g;
   endfunction

   task automatic addVec(input logic rst, input logic [NW-1:0] valid, input logic [NW-1:0] stall,
                         input logic ready, input logic fv, input logic [2:0] fw,
                         input logic [NW-1:0] e_rdy, input logic e_vld, input logic [2:0] e_wid);
      vec_t v;
      v.rst = rst; v.valid = valid; v.stall = stall; v.ready = ready; v.fv = fv; v.fw = fw;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_wid = e_wid;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic rst, input logic [NW-1:0] valid, input logic [NW-1:0] stall,
                                input logic ready, input logic fv, input logic [2:0] fw);
      reset       = rst;
      ibuf_valid  = valid;
      warp_stall  = stall;
      iss_ready   = ready;
      flush_valid = fv;
      flush_wid   = fw;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic fixedPayloads();
      for (int g = 0; g < NW; g++) begin
         ibuf_pc[g*32 +: 32]    = pc_of(g);
         ibuf_raw[g*64 +: 64]   = raw_of(g);
         ibuf_tmask[g*16 +: 16] = tmask_of(g);
      end
   endtask

   // Spec rule: first eligible warp searching upward from last+1 modulo NW.
   function automatic int modelPick(input logic [NW-1:0] v, input logic [NW-1:0] s,
                                    input logic fv, input logic [2:0] fw, input int last);
      for (int k = 1; k <= NW; k++) begin
         int w;
         w = (last + k) % NW;
         if (v[w] && !s[w] && !(fv && int'(fw) == w)) return w;
      end
      return -1;
   endfunction

   task automatic nextEdge();
      @(posedge clock);
      #1;
   endtask

   initial begin
      applyStimulus(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0);
      fixedPayloads();
      #1;
      nextEdge();
      nextEdge();

      // Reset state, with every head valid: nothing may be dequeued.
      @(negedge clock);
      checkOutput("reset_ibuf_ready", 64'(ibuf_ready), 64'h0);
      checkOutput("reset_iss_valid", 64'(iss_valid), 64'h0);
      checkOutput("reset_iss_wid", 64'(iss_wid), 64'h0);
      checkOutput("reset_iss_pc", 64'(iss_pc), 64'h0);
      checkOutput("reset_iss_raw", iss_raw, 64'h0);
      checkOutput("reset_iss_tmask", 64'(iss_tmask), 64'h0);
      nextEdge();

      // Directed vectors: rst valid stall ready fv fw | ibuf_ready iss_valid iss_wid.
      addVec(1, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 0, 0);
      addVec(0, 8'h01, 8'h00, 1, 0, 0, 8'h01, 0, 0);
      addVec(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 0);
      addVec(1, 8'hFF, 8'h00, 1, 0, 0, 8'h00, 0, 0);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h01, 0, 0);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h02, 1, 0);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h04, 1, 1);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h08, 1, 2);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h10, 1, 3);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h20, 1, 4);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h40, 1, 5);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h80, 1, 6);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h01, 1, 7);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h02, 1, 0);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h04, 1, 1);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h08, 1, 2);
      for (int i = 0; i < 5; i++) addVec(0, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 1, 3);
      addVec(0, 8'hFF, 8'h00, 1, 0, 0, 8'h10, 1, 3);
      addVec(1, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 4);
      addVec(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0);
      addVec(0, 8'h0C, 8'h04, 1, 0, 0, 8'h08, 0, 0);
      addVec(0, 8'h0C, 8'h00, 1, 0, 0, 8'h04, 1, 3);
      addVec(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 2);
      addVec(0, 8'h20, 8'h00, 1, 0, 0, 8'h20, 0, 0);
      addVec(0, 8'h60, 8'h00, 0, 1, 5, 8'h00, 1, 5);
      addVec(0, 8'h60, 8'h00, 0, 1, 5, 8'h40, 0, 0);
      addVec(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 6);
      addVec(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 1, 6);
      addVec(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].stall, vecs[i].ready, vecs[i].fv, vecs[i].fw);
         @(negedge clock);
         checkOutput($sformatf("vec%0d_ibuf_ready", i), 64'(ibuf_ready), 64'(vecs[i].e_rdy));
         checkOutput($sformatf("vec%0d_iss_valid", i), 64'(iss_valid), 64'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            checkOutput($sformatf("vec%0d_iss_wid", i), 64'(iss_wid), 64'(vecs[i].e_wid));
            checkOutput($sformatf("vec%0d_iss_pc", i), 64'(iss_pc), 64'(pc_of(int'(vecs[i].e_wid))));
            checkOutput($sformatf("vec%0d_iss_raw", i), iss_raw, raw_of(int'(vecs[i].e_wid)));
            checkOutput($sformatf("vec%0d_iss_tmask", i), 64'(iss_tmask), 64'(tmask_of(int'(vecs[i].e_wid))));
            if (vecs[i].fv && iss_ready && iss_wid == vecs[i].fw)
               checkOutput($sformatf("vec%0d_flushed_issue", i), 64'(1), 64'(0));
         end
         nextEdge();
      end

`ifdef ISSUE_ARBITER_PERF_EN
      // Perf counters: four completed issues, three backpressured cycles.
      applyStimulus(1, 8'h00, 8'h00, 1, 0, 0);
      nextEdge();
      applyStimulus(0, 8'h01, 8'h00, 1, 0, 0);
      nextEdge();
      applyStimulus(0, 8'h00, 8'h00, 0, 0, 0);
      nextEdge(); nextEdge(); nextEdge();
      applyStimulus(0, 8'h01, 8'h00, 1, 0, 0);
      nextEdge(); nextEdge(); nextEdge();
      applyStimulus(0, 8'h00, 8'h00, 1, 0, 0);
      nextEdge();
      @(negedge clock);
      checkOutput("perf_issued", 64'(perf_issued), 64'd4);
      checkOutput("perf_backpressure", 64'(perf_backpressure), 64'd3);
      applyStimulus(1, 8'h00, 8'h00, 1, 0, 0);
      nextEdge();
      @(negedge clock);
      checkOutput("perf_issued_reset", 64'(perf_issued), 64'd0);
      checkOutput("perf_backpressure_reset", 64'(perf_backpressure), 64'd0);
      nextEdge();
`endif

      // Randomized traffic against the model; begins from a reset.
      m_valid = 1'b0; m_wid = '0; m_pc = '0; m_raw = '0; m_tmask = '0; m_last = NW - 1;
      applyStimulus(1, 8'h00, 8'h00, 1, 0, 0);
      nextEdge();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int win;
         logic load_en;
         applyStimulus($urandom_range(0, 63) == 0, 8'($urandom), 8'($urandom) & 8'($urandom),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 3'($urandom));
         if ($urandom_range(0, 1) == 1) flush_wid = m_wid;
         for (int g = 0; g < NW; g++) begin
            ibuf_pc[g*32 +: 32]    = $urandom;
            ibuf_raw[g*64 +: 64]   = {$urandom, $urandom};
            ibuf_tmask[g*16 +: 16] = 16'($urandom);
         end
         @(negedge clock);
         load_en = !m_valid || iss_ready;
         win = modelPick(ibuf_valid, warp_stall, flush_valid, flush_wid, m_last);
         if (reset || !load_en || win < 0)
            checkOutput("rand_ibuf_ready", 64'(ibuf_ready), 64'h0);
         else
            checkOutput("rand_ibuf_ready", 64'(ibuf_ready), 64'(1) << win);
         checkOutput("rand_iss_valid", 64'(iss_valid), 64'(m_valid));
         if (m_valid) begin
            checkOutput("rand_iss_wid", 64'(iss_wid), 64'(m_wid));
            checkOutput("rand_iss_pc", 64'(iss_pc), 64'(m_pc));
            checkOutput("rand_iss_raw", iss_raw, m_raw);
            checkOutput("rand_iss_tmask", 64'(iss_tmask), 64'(m_tmask));
         end
         if (reset) begin
            m_valid = 1'b0; m_wid = '0; m_pc = '0; m_raw = '0; m_tmask = '0; m_last = NW - 1;
         end else if (load_en && win >= 0) begin
            m_valid = 1'b1;
            m_wid   = 3'(win);
            m_pc    = ibuf_pc[win*32 +: 32];
            m_raw   = ibuf_raw[win*64 +: 64];
            m_tmask = ibuf_tmask[win*16 +: 16];
            m_last  = win;
         end else if (load_en) begin
            m_valid = 1'b0;
         end else if (flush_valid && flush_wid == m_wid) begin
            m_valid = 1'b0;
         end
         nextEdge();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/issue_arbiter.md
ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warps and ibuf heads.
REQ-002 SHALL have parameter ARCH_LEN, default 32, PC width.
REQ-003 SHALL have parameter INST_BITS, default 64, raw instruction width.
REQ-004 SHALL have parameter NUM_LANES, default 16, thread-mask width; WID_BITS = clog2(NUM_WARPS).
REQ-005 SHALL have port clock, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port ibuf_valid, input, NUM_WARPS, per-warp head valid.
REQ-008 SHALL have port ibuf_ready, output, NUM_WARPS, per-warp head dequeue.
REQ-009 SHALL have ports ibuf_pc, ibuf_raw and ibuf_tmask, all inputs, packed NUM_WARPS*ARCH_LEN, NUM_WARPS*INST_BITS and NUM_WARPS*NUM_LANES; warp g occupies slice [W*g +: W].
REQ-010 SHALL have port warp_stall, input, NUM_WARPS, scoreboard/barrier hold per warp.
REQ-011 SHALL have ports flush_valid, input, 1, and flush_wid, input, WID_BITS; together they kill one warp's in-flight issue.
REQ-012 SHALL have ports iss_valid, output, 1, and iss_ready, input, 1; these form the issue handshake.
REQ-013 SHALL have ports iss_wid, iss_pc, iss_raw and iss_tmask, all outputs, widths WID_BITS, ARCH_LEN, INST_BITS and NUM_LANES; they carry the issued instruction.

Function
REQ-014 SHALL hold a single-entry output register driving all iss_* outputs directly, with no combinational path from inputs to iss_*.
REQ-015 SHALL compute load_en = !iss_valid || iss_ready.
REQ-016 SHALL define the candidate set as ibuf_valid & ~warp_stall & ~(flush_valid ? onehot(flush_wid) : 0).
REQ-017 SHALL select the winner by round-robin: the first candidate searched upward from last_grant+1 modulo NUM_WARPS.
REQ-018 SHALL drive ibuf_ready one-hot to the winner only when load_en is high and the candidate set is non-empty; otherwise ibuf_ready SHALL be all zero.
REQ-019 SHALL never assert ibuf_ready for a warp whose ibuf_valid is low, whose warp_stall is high, or that is being flushed.
REQ-020 SHALL, on a grant, load the winner's pc/raw/tmask and wid into the register, set iss_valid on the next cycle, and set last_grant to the winner (latency 1 cycle).
REQ-021 SHALL clear iss_valid when load_en is high and there is no grant.
REQ-022 SHALL hold the register and iss_valid stable while iss_valid is high and iss_ready is low.
REQ-023 SHALL handle a flush matching the held iss_wid as follows: if the cycle has iss_valid && iss_ready, the transfer completes; otherwise iss_valid is cleared at the edge. A same-cycle grant to a different warp SHALL still load.
REQ-024 SHALL reach back-to-back throughput of one issue per cycle when iss_ready is held high.
REQ-025 SHALL keep last_grant unchanged in cycles with no grant.
REQ-026 SHALL wrap the search past warp NUM_WARPS-1 to warp 0.

Reset
REQ-027 SHALL, while reset is high, clear iss_valid, iss_wid, iss_pc, iss_raw and iss_tmask to 0 and drive ibuf_ready to 0.
REQ-028 SHALL set last_grant to NUM_WARPS-1 on reset, so warp 0 has first priority.
REQ-029 SHALL discard an in-flight entry when reset is asserted mid-operation, with no handshake produced.

Configuration
REQ-030 SHALL compile performance counters in when ISSUE_ARBITER_PERF_EN is defined: outputs perf_issued (32 bits), counting iss_valid && iss_ready cycles, and perf_backpressure (32 bits), counting iss_valid && !iss_ready cycles; both wrap at 2^32 and reset to 0.
REQ-031 SHALL have neither the perf ports nor the counter logic when ISSUE_ARBITER_PERF_EN is undefined; all other behaviour is identical in both builds.

Verification
REQ-032 SHALL cover single-warp issue: after reset, ibuf_valid=0x01, pc0=0x8000_0000, iss_ready=1 -> ibuf_ready=0x01 that cycle; next cycle iss_valid=1, iss_wid=0, iss_pc=0x8000_0000.
REQ-033 SHALL cover round-robin order: ibuf_valid=0xFF held, iss_ready=1 for 10 cycles -> grants in order 0,1,2,...,7,0,1.
REQ-034 SHALL cover backpressure: iss_valid=1 with iss_wid=3 and iss_ready=0 for 5 cycles -> ibuf_ready=0, outputs stable; iss_ready=1 -> the next warp after 3 is granted in the same cycle.
REQ-035 SHALL cover stall masking: ibuf_valid=0x0C and warp_stall=0x04 -> only warp 3 is granted; warp_stall=0x00 -> warp 2 is granted next.
REQ-036 SHALL cover flush: held entry iss_wid=5, iss_ready=0, flush_valid=1, flush_wid=5, ibuf_valid=0x60 -> warp 6 is granted, and next cycle iss_wid=6 with no warp-5 issue ever observed.
REQ-037 SHALL cover perf counters with ISSUE_ARBITER_PERF_EN defined: 4 issues and 3 backpressure cycles -> perf_issued=4 and perf_backpressure=3; reset -> both read 0.
